// File: rtl/shift_reg_readout_checker.sv
// shift_reg_readout_checker
// Captures the serial output of the pixel shift register once per phase-2
// pulse and checks each frame against a walking-one pattern. It reports
// pass/fail for each frame, saturating frame and error counters, and an
// abort on timeout.
// Optional feature: define OVERLAP_CHECK_EN to compile in the sticky
// phi1/phi2 overlap detector. When it is undefined, overlap_err is tied to 0.
module shift_reg_readout_checker #(
    parameter int N_STAGES    = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200000
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                phi1,
    input  logic                phi2,
    input  logic                d_inj,
    input  logic                sr_out,
    output logic [N_STAGES-1:0] capture_word,
    output logic                frame_done,
    output logic                pass,
    output logic                fail,
    output logic                timeout_err,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         err_cnt,
    output logic                overlap_err
);

    localparam int IDX_W = $clog2(N_STAGES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [N_STAGES-1:0] EXPECTED = {1'b1, {(N_STAGES-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, ABORT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] phi1_sync, phi2_sync, d_sync, sr_sync;
    logic                   phi1_s, phi2_s, d_s, sr_s;
    logic                   phi1_prev, phi2_prev;
    logic                   phi1_rise, phi2_rise;
    logic [IDX_W-1:0]       idx;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [N_STAGES-1:0]    word;
    logic                   last_sample, tmo_hit, match;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign phi1_s      = phi1_sync[SYNC_STAGES-1];
    assign phi2_s      = phi2_sync[SYNC_STAGES-1];
    assign d_s         = d_sync[SYNC_STAGES-1];
    assign sr_s        = sr_sync[SYNC_STAGES-1];
    assign phi1_rise   = phi1_s & ~phi1_prev;
    assign phi2_rise   = phi2_s & ~phi2_prev;
    assign last_sample = phi2_rise && (idx == IDX_W'(N_STAGES - 1));
    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign match       = (word == EXPECTED);

    // Bring the asynchronous pad signals into clk_in and keep the previous
    // phase levels so that rising edges can be detected.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            phi1_sync <= '0;
            phi2_sync <= '0;
            d_sync    <= '0;
            sr_sync   <= '0;
            phi1_prev <= 1'b0;
            phi2_prev <= 1'b0;
        end else begin
            phi1_sync <= {phi1_sync[SYNC_STAGES-2:0], phi1};
            phi2_sync <= {phi2_sync[SYNC_STAGES-2:0], phi2};
            d_sync    <= {d_sync[SYNC_STAGES-2:0], d_inj};
            sr_sync   <= {sr_sync[SYNC_STAGES-2:0], sr_out};
            phi1_prev <= phi1_s;
            phi2_prev <= phi2_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic. A sample on the timeout cycle takes priority over the abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (phi1_rise && d_s) state_next = CAPTURE;
            CAPTURE: begin
                if (phi2_rise) begin
                    if (last_sample) state_next = CHECK;
                end else if (tmo_hit) begin
                    state_next = ABORT;
                end
            end
            CHECK:   state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sample capture, timeout counting and the registered frame results.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            tmo_cnt      <= '0;
            word         <= '0;
            capture_word <= '0;
            frame_done   <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout_err  <= 1'b0;
            frame_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (phi1_rise && d_s) begin
                        idx     <= '0;
                        tmo_cnt <= '0;
                        word    <= '0;
                    end
                end
                CAPTURE: begin
                    if (phi2_rise) begin
                        for (int j = 0; j < N_STAGES; j++) begin
                            if (idx == IDX_W'(j)) word[j] <= sr_s;
                        end
                        idx     <= idx + IDX_W'(1);
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                CHECK: begin
                    capture_word <= word;
                    pass         <= match;
                    fail         <= !match;
                    timeout_err  <= 1'b0;
                    frame_done   <= 1'b1;
                    frame_cnt    <= sat_inc(frame_cnt);
                    if (!match) err_cnt <= sat_inc(err_cnt);
                end
                ABORT: begin
                    capture_word <= word;
                    pass         <= 1'b0;
                    fail         <= 1'b1;
                    timeout_err  <= 1'b1;
                    frame_done   <= 1'b1;
                    frame_cnt    <= sat_inc(frame_cnt);
                    err_cnt      <= sat_inc(err_cnt);
                end
                default: ;
            endcase
        end
    end

`ifdef OVERLAP_CHECK_EN
    // Sticky flag: both phase clocks were seen high in the same cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)                overlap_err <= 1'b0;
        else if (phi1_s && phi2_s) overlap_err <= 1'b1;
    end
`else
    assign overlap_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_readout_checker.sv
// Bench for shift_reg_readout_checker: randomized frames checked by a
// frame-level scoreboard, plus literal expectations for the plan scenarios.
module tb_shift_reg_readout_checker;

    localparam int N    = 10;
    localparam int SYNC = 2;
    localparam int TMO  = 64;
`ifdef OVERLAP_CHECK_EN
    localparam bit OVL_EN = 1'b1;
`else
    localparam bit OVL_EN = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         reset  = 1'b0;
    logic         phi1 = 1'b0, phi2 = 1'b0, d_inj = 1'b0, sr_out = 1'b0;
    logic [N-1:0] capture_word;
    logic         frame_done, pass, fail, timeout_err, overlap_err;
    logic [15:0]  frame_cnt, err_cnt;

    shift_reg_readout_checker #(.N_STAGES(N), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk_in(clk_in), .reset(reset), .phi1(phi1), .phi2(phi2), .d_inj(d_inj),
        .sr_out(sr_out), .capture_word(capture_word), .frame_done(frame_done),
        .pass(pass), .fail(fail), .timeout_err(timeout_err), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .overlap_err(overlap_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference model: what each finished frame must report.
    typedef struct {
        logic [N-1:0] word;
        bit           to;
    } exp_t;
    exp_t         q[$];
    exp_t         cur;
    logic [N-1:0] m_word = '0;
    bit           m_pass = 0, m_fail = 0, m_to = 0, m_ovl = 0, ovl_pending = 0;
    int           m_fc = 0, m_ec = 0;

    // Compare every cycle. On frame_done, retire one expected frame first.
    always @(negedge clk_in) begin
        if (!reset) begin
            m_word = '0; m_pass = 0; m_fail = 0; m_to = 0; m_ovl = 0;
            m_fc = 0; m_ec = 0; q.delete();
        end else if (frame_done) begin
            if (q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                cur    = q.pop_front();
                m_word = cur.word;
                m_to   = cur.to;
                m_pass = !cur.to && (cur.word == N'(1 << (N - 1)));
                m_fail = !m_pass;
                m_fc   = (m_fc < 65535) ? m_fc + 1 : m_fc;
                if (m_fail) m_ec = (m_ec < 65535) ? m_ec + 1 : m_ec;
            end
        end
        check("capture_word", 32'(capture_word), 32'(m_word));
        check("pass", 32'(pass), 32'(m_pass));
        check("fail", 32'(fail), 32'(m_fail));
        check("timeout_err", 32'(timeout_err), 32'(m_to));
        check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        check("err_cnt", 32'(err_cnt), 32'(m_ec));
        if (!ovl_pending) check("overlap_err", 32'(overlap_err), 32'(m_ovl));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic int rw();
        return $urandom_range(SYNC + 2, 8);
    endfunction

    // Drive npulse phi1/phi2 pairs, presenting bits[i] on sr_out during the
    // i-th phi2 pulse and noise elsewhere. ovl_at picks a pulse whose phi2
    // overlaps the following phi1 rise (-1 for none).
    task automatic run_frame(input int npulse, input logic [N-1:0] bits,
                             input bit pre_bad, input int ovl_at);
        bit p1_high = 0;
        if (pre_bad) begin
            d_inj = 0; phi1 = 1; tick(rw()); phi1 = 0; tick(3);
            sr_out = 1; phi2 = 1; tick(rw()); phi2 = 0; sr_out = 0; tick(4);
        end
        for (int i = 0; i < npulse; i++) begin
            if (i == 0) begin
                d_inj = 1; tick(1);
            end else begin
                d_inj = 1'($urandom_range(0, 1));
            end
            phi1 = 1;
            tick(rw());
            phi1 = 0; p1_high = 0;
            tick(1);
            d_inj = 0;
            tick($urandom_range(1, 3));
            sr_out = bits[i];
            tick(1);
            phi2 = 1;
            tick(rw());
            if (i == ovl_at && i < npulse - 1) begin
                ovl_pending = 1; phi1 = 1; p1_high = 1;
                tick(5);
                phi2 = 0;
                tick(SYNC + 3);
                if (OVL_EN) m_ovl = 1;
                ovl_pending = 0;
            end else begin
                phi2 = 0;
            end
            sr_out = 1'($urandom_range(0, 1));
            if (!p1_high) tick($urandom_range(1, 3));
        end
        sr_out = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
        q.delete();
        tick(2);
    endtask

    localparam logic [N-1:0] NOMINAL = 10'b10_0000_0000;

    initial begin
        logic [N-1:0] bits, mask;
        int           k, t;
        tick(3);
        check("reset_capture_word", 32'(capture_word), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1; tick(2);

        // Nominal frame.
        q.push_back('{NOMINAL, 1'b0});
        run_frame(N, NOMINAL, 0, -1);
        wait_done("nominal_done", 40);
        check("nominal_word", 32'(capture_word), 32'h200);
        check("nominal_pass", 32'(pass), 32'd1);
        check("nominal_frame_cnt", 32'(frame_cnt), 32'd1);
        check("nominal_err_cnt", 32'(err_cnt), 32'd0);

        // Stuck-at-0 register.
        q.push_back('{'0, 1'b0});
        run_frame(N, '0, 0, -1);
        wait_done("stuck0_done", 40);
        check("stuck0_word", 32'(capture_word), 32'd0);
        check("stuck0_fail", 32'(fail), 32'd1);
        check("stuck0_err_cnt", 32'(err_cnt), 32'd1);

        // Timeout after 4 samples 1,0,1,1.
        q.push_back('{10'b00_0000_1101, 1'b1});
        run_frame(4, 10'b00_0000_1101, 0, -1);
        wait_done("timeout_done", TMO + 40);
        check("timeout_word", 32'(capture_word), 32'h00D);
        check("timeout_flag", 32'(timeout_err), 32'd1);
        check("timeout_frame_cnt", 32'(frame_cnt), 32'd3);
        check("timeout_err_cnt", 32'(err_cnt), 32'd2);

        // Start qualification: an unqualified phi1 and a stray phi2 come first.
        q.push_back('{NOMINAL, 1'b0});
        run_frame(N, NOMINAL, 1, -1);
        wait_done("qual_done", 40);
        check("qual_pass", 32'(pass), 32'd1);
        check("qual_frame_cnt", 32'(frame_cnt), 32'd4);

        // Overlap between a phi2 pulse and the next phi1 pulse.
        q.push_back('{NOMINAL, 1'b0});
        run_frame(N, NOMINAL, 0, 4);
        wait_done("ovl_done", 40);
        check("ovl_pass", 32'(pass), 32'd1);
        check("ovl_flag", 32'(overlap_err), 32'(OVL_EN));

        // Mid-frame reset after 5 samples, then a fresh nominal frame.
        run_frame(5, NOMINAL, 0, -1);
        reset = 0; tick(3);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        check("midrst_ovl", 32'(overlap_err), 32'd0);
        reset = 1; tick(2);
        q.push_back('{NOMINAL, 1'b0});
        run_frame(N, NOMINAL, 0, -1);
        wait_done("post_rst_done", 40);
        check("post_rst_pass", 32'(pass), 32'd1);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            t = $urandom_range(0, 4);
            bits = N'($urandom);
            case (t)
                0: bits = NOMINAL;
                2: bits = '0;
                4: bits = NOMINAL;
                default: ;
            endcase
            if (t == 3) begin
                k = $urandom_range(1, N - 1);
                mask = (N'(1) << k) - N'(1);
                q.push_back('{bits & mask, 1'b1});
                run_frame(k, bits, 1'($urandom_range(0, 1)), -1);
                wait_done("rand_timeout_done", TMO + 40);
            end else begin
                q.push_back('{bits, 1'b0});
                run_frame(N, bits, 1'($urandom_range(0, 1)),
                          (t == 4) ? $urandom_range(0, N - 2) : -1);
                wait_done("rand_done", 40);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_readout_checker.md
# shift_reg_readout_checker

Downstream capture and check stage for the shift-register test system. It observes the two non-overlapping phase clocks and the injected data bit that the test driver applies to the pixel shift register. It samples the register's serial output once per phase-2 pulse and compares the assembled word against the expected walking-one pattern. It reports per-frame pass/fail, saturating frame and error counters, and protocol faults, so a bench or board LEDs can judge each test run without a scope.

## Interface
- `N_STAGES`, 10: shift-register length; equals the number of phase-1 pulses per frame.
- `SYNC_STAGES`, 2: synchroniser depth on all four observed inputs (minimum 2).
- `TIMEOUT`, 200000: clk_in cycles allowed between consecutive phase-2 samples before a frame aborts.
- `clk_in` input 1: system clock; all logic rises on posedge.
- `reset` input 1: asynchronous, active-low reset.
- `phi1` input 1: phase-1 (positive) shift clock as driven to the register.
- `phi2` input 1: phase-2 (negative) shift clock.
- `d_inj` input 1: data bit driven into register stage 1.
- `sr_out` input 1: serial output of the last register stage.
- `capture_word` output N_STAGES: last completed frame; sample j (1-based) at bit j-1.
- `frame_done` output 1: one-cycle pulse per completed or aborted frame.
- `pass` output 1: last frame matched the expected pattern.
- `fail` output 1: last frame mismatched or aborted.
- `timeout_err` output 1: last frame aborted by timeout.
- `frame_cnt` output 16: completed plus aborted frames, saturating.
- `err_cnt` output 16: failed plus aborted frames, saturating.
- `overlap_err` output 1: sticky; phi1 and phi2 were seen high together.

## Operation
- All four inputs pass through SYNC_STAGES flops. Edge detection uses the synchronised copies only.
- FSM states: IDLE, CAPTURE, CHECK, ABORT.
- IDLE:
  - A phi1 rising edge with synchronised d_inj = 1 clears the sample index and timeout counter, then moves to CAPTURE.
  - A phi1 rise with d_inj = 0 is ignored.
  - A phi2 rise is ignored.
- CAPTURE:
  - Each phi2 rising edge stores synchronised sr_out at bit index, increments index and clears the timeout counter.
  - The N_STAGES-th sample moves to CHECK on the next cycle.
  - d_inj and phi1 are not examined in CAPTURE.
  - The timeout counter increments every cycle. When it reaches TIMEOUT, the FSM moves to ABORT.
- CHECK (one cycle):
  - Expected word is only bit N_STAGES-1 set.
  - Load capture_word. Set pass = (word == expected) and fail = !pass. Clear timeout_err.
  - Pulse frame_done. Increment frame_cnt. Increment err_cnt on fail. Return to IDLE.
- ABORT (one cycle):
  - capture_word takes the partial word, with unsampled bits 0.
  - pass = 0, fail = 1, timeout_err = 1.
  - Pulse frame_done. Increment frame_cnt and err_cnt. Return to IDLE.
- pass, fail, timeout_err and capture_word hold until the next frame_done.
- Counters stick at 16'hFFFF and do not wrap.
- A phi2 rise in the same cycle the timeout count reaches TIMEOUT counts as a sample; the sample wins.
- Reset (any time, including mid-frame):
  - All outputs, counters, synchronisers and index go to 0. overlap_err clears.
  - FSM goes to IDLE.
  - The first frame after release needs a fresh phi1 rise with d_inj = 1.

## Timing
- Input-to-detection latency: SYNC_STAGES + 1 cycles from pad edge to the edge-detect pulse.
- frame_done asserts in the cycle after the N_STAGES-th sample is stored, and stays high exactly one cycle.
- Outputs are registered; pass/fail/capture_word/counters change in the same edge that raises frame_done.
- Minimum supported phase pulse width is SYNC_STAGES + 2 clk_in cycles. Narrower pulses may be missed.
- Back-to-back frames: an IDLE start condition is accepted the cycle after CHECK or ABORT.

## Configuration
- `OVERLAP_CHECK_EN` defined:
  - Each cycle in which synchronised phi1 and phi2 are both 1 sets overlap_err.
  - overlap_err stays set until reset. FSM behaviour is unaffected.
- Not defined: the overlap logic is not compiled in and overlap_err is tied to 0.

## Test plan
- Nominal frame: 10 phi1/phi2 pulse pairs, d_inj high around the first phi1, sr_out high only during the 10th phi2 -> capture_word = 10'b10_0000_0000, pass = 1, frame_cnt = 1, err_cnt = 0.
- Stuck-at-0 register: same stimulus with sr_out held 0 -> capture_word = 0, fail = 1, err_cnt = 1.
- Timeout: stop phi2 after 4 pulses, wait TIMEOUT cycles -> frame_done with timeout_err = 1, capture_word = bits 3..0 as sampled, frame_cnt += 1, err_cnt += 1.
- Mid-frame reset: assert reset after the 5th phi2, release, then run a nominal frame -> all outputs 0 during reset; post-release frame passes; frame_cnt = 1.
- Start qualification: phi1 pulse with d_inj = 0 in IDLE, then a nominal frame -> first pulse ignored; exactly one frame_done; pass = 1.
- Overlap (OVERLAP_CHECK_EN defined): phi1 and phi2 both high for 5 cycles mid-frame -> overlap_err = 1 and stays set; frame still completes. Not defined: overlap_err stays 0.
